// File: rtl/ram_bus_arbiter_pkg.sv
// Shared encodings and defaults for the RAM bus arbiter slice.
// Imported by ram_bus_arbiter and the testbench.
package ram_bus_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } arb_owner_t;

  // Saturating increment for the IF starvation counter.
  function automatic logic [3:0] sat_inc(input logic [3:0] val, input logic [3:0] lim);
    return (val >= lim) ? lim : val + 4'd1;
  endfunction

endpackage

// File: rtl/ram_arb_perf_cnt.sv
// Generic 32-bit event counter with enable; wraps modulo 2^32.
// Used by ram_bus_arbiter only when RAM_ARB_PERF_CNT_EN is defined.
module ram_arb_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [31:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Shares one RAM bus between instruction fetch (read-only) and load/store,
// MEM first with an IF starvation guard. Optional counters: RAM_ARB_PERF_CNT_EN.
module ram_bus_arbiter
  import ram_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                if_req_valid_i,
  input  logic [ADDR_W-1:0]   if_req_addr_i,
  output logic                if_resp_valid_o,
  output logic [DATA_W-1:0]   if_resp_data_o,
  input  logic                if_flush_i,

  input  logic                mem_req_valid_i,
  input  logic                mem_req_we_i,
  input  logic [ADDR_W-1:0]   mem_req_addr_i,
  input  logic [DATA_W-1:0]   mem_req_wdata_i,
  input  logic [DATA_W/8-1:0] mem_req_wmask_i,
  output logic                mem_resp_valid_o,
  output logic [DATA_W-1:0]   mem_resp_data_o,

  output logic                bus_req_valid_o,
  input  logic                bus_req_ready_i,
  output logic                bus_req_we_o,
  output logic [ADDR_W-1:0]   bus_req_addr_o,
  output logic [DATA_W-1:0]   bus_req_wdata_o,
  output logic [DATA_W/8-1:0] bus_req_wmask_o,
  input  logic                bus_resp_valid_i,
  input  logic [DATA_W-1:0]   bus_resp_data_i,

  output logic                ram_stall_if_o,
  output logic                ram_stall_mem_o
`ifdef RAM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]         perf_if_grants_o,
  output logic [31:0]         perf_mem_grants_o,
  output logic [31:0]         perf_conflict_o
`endif
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arb_state_t          state;
  arb_state_t          state_nxt;
  arb_owner_t          owner;
  logic [3:0]          starve_cnt;
  logic                drop;
  logic [DATA_W-1:0]   if_data_q;
  logic [DATA_W-1:0]   mem_data_q;

  logic                in_idle;
  logic                grant_mem;
  logic                grant_if;
  logic                resp_done;

  // IF overrides MEM only once it has watched STARVE_MAX MEM grants go by.
  assign in_idle   = (state == ST_IDLE);
  assign grant_mem = in_idle & mem_req_valid_i &
                     ~(if_req_valid_i & (starve_cnt == STARVE_LIM));
  assign grant_if  = in_idle & if_req_valid_i & ~grant_mem;
  assign resp_done = (state == ST_RESP) & bus_resp_valid_i;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: combinational blocks assign a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (grant_mem || grant_if) state_nxt = ST_REQ;
      ST_REQ:  if (bus_req_ready_i)       state_nxt = ST_RESP;
      ST_RESP: if (bus_resp_valid_i)      state_nxt = ST_IDLE;
      default:                            state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_req_valid_o  = 1'b0;
    if_resp_valid_o  = 1'b0;
    mem_resp_valid_o = 1'b0;
    if (!rst) begin
      bus_req_valid_o = (state == ST_REQ);
      if (resp_done) begin
        if (owner == OWN_MEM) begin
          mem_resp_valid_o = 1'b1;
        end else begin
          // A flush landing on the response cycle itself also kills the pulse.
          if_resp_valid_o = ~drop & ~if_flush_i;
        end
      end
    end
  end

  // Request fields are only loaded on a grant, so they hold through REQ.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner           <= OWN_IF;
      starve_cnt      <= '0;
      drop            <= 1'b0;
      bus_req_we_o    <= 1'b0;
      bus_req_addr_o  <= '0;
      bus_req_wdata_o <= '0;
      bus_req_wmask_o <= '0;
      if_data_q       <= '0;
      mem_data_q      <= '0;
    end else begin
      if (grant_mem) begin
        owner           <= OWN_MEM;
        bus_req_we_o    <= mem_req_we_i;
        bus_req_addr_o  <= mem_req_addr_i;
        bus_req_wdata_o <= mem_req_wdata_i;
        bus_req_wmask_o <= mem_req_wmask_i;
      end else if (grant_if) begin
        owner           <= OWN_IF;
        bus_req_we_o    <= 1'b0;
        bus_req_addr_o  <= if_req_addr_i;
        bus_req_wdata_o <= '0;
        bus_req_wmask_o <= '0;
      end

      if (!if_req_valid_i || grant_if) begin
        starve_cnt <= '0;
      end else if (grant_mem) begin
        starve_cnt <= sat_inc(starve_cnt, STARVE_LIM);
      end

      if (resp_done) begin
        drop <= 1'b0;
      end else if (if_flush_i && (grant_if || (owner == OWN_IF && !in_idle))) begin
        drop <= 1'b1;
      end

      if (if_resp_valid_o)  if_data_q  <= bus_resp_data_i;
      if (mem_resp_valid_o) mem_data_q <= bus_resp_data_i;
    end
  end

  assign if_resp_data_o  = if_resp_valid_o  ? bus_resp_data_i : if_data_q;
  assign mem_resp_data_o = mem_resp_valid_o ? bus_resp_data_i : mem_data_q;

  assign ram_stall_if_o  = if_req_valid_i  & ~if_resp_valid_o;
  assign ram_stall_mem_o = mem_req_valid_i & ~mem_resp_valid_o;

`ifdef RAM_ARB_PERF_CNT_EN
  ram_arb_perf_cnt u_perf_if (
    .clk   (clk),
    .rst   (rst),
    .en    (grant_if),
    .count (perf_if_grants_o)
  );

  ram_arb_perf_cnt u_perf_mem (
    .clk   (clk),
    .rst   (rst),
    .en    (grant_mem),
    .count (perf_mem_grants_o)
  );

  ram_arb_perf_cnt u_perf_conflict (
    .clk   (clk),
    .rst   (rst),
    .en    (in_idle & if_req_valid_i & mem_req_valid_i),
    .count (perf_conflict_o)
  );
`endif

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Directed bench for ram_bus_arbiter: grant order, starvation guard,
// backpressure, IF flush and reset-mid-transaction, with hand-derived values.
module tb_ram_bus_arbiter;
  import ram_bus_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int MW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_valid_i;
  logic [AW-1:0] if_req_addr_i;
  logic          if_resp_valid_o;
  logic [DW-1:0] if_resp_data_o;
  logic          if_flush_i;
  logic          mem_req_valid_i;
  logic          mem_req_we_i;
  logic [AW-1:0] mem_req_addr_i;
  logic [DW-1:0] mem_req_wdata_i;
  logic [MW-1:0] mem_req_wmask_i;
  logic          mem_resp_valid_o;
  logic [DW-1:0] mem_resp_data_o;
  logic          bus_req_valid_o;
  logic          bus_req_ready_i;
  logic          bus_req_we_o;
  logic [AW-1:0] bus_req_addr_o;
  logic [DW-1:0] bus_req_wdata_o;
  logic [MW-1:0] bus_req_wmask_o;
  logic          bus_resp_valid_i;
  logic [DW-1:0] bus_resp_data_i;
  logic          ram_stall_if_o;
  logic          ram_stall_mem_o;
`ifdef RAM_ARB_PERF_CNT_EN
  logic [31:0]   perf_if_grants_o;
  logic [31:0]   perf_mem_grants_o;
  logic [31:0]   perf_conflict_o;
`endif

  int total = 0;
  int bad   = 0;

  ram_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .if_req_valid_i   (if_req_valid_i),
    .if_req_addr_i    (if_req_addr_i),
    .if_resp_valid_o  (if_resp_valid_o),
    .if_resp_data_o   (if_resp_data_o),
    .if_flush_i       (if_flush_i),
    .mem_req_valid_i  (mem_req_valid_i),
    .mem_req_we_i     (mem_req_we_i),
    .mem_req_addr_i   (mem_req_addr_i),
    .mem_req_wdata_i  (mem_req_wdata_i),
    .mem_req_wmask_i  (mem_req_wmask_i),
    .mem_resp_valid_o (mem_resp_valid_o),
    .mem_resp_data_o  (mem_resp_data_o),
    .bus_req_valid_o  (bus_req_valid_o),
    .bus_req_ready_i  (bus_req_ready_i),
    .bus_req_we_o     (bus_req_we_o),
    .bus_req_addr_o   (bus_req_addr_o),
    .bus_req_wdata_o  (bus_req_wdata_o),
    .bus_req_wmask_o  (bus_req_wmask_o),
    .bus_resp_valid_i (bus_resp_valid_i),
    .bus_resp_data_i  (bus_resp_data_i),
    .ram_stall_if_o   (ram_stall_if_o),
    .ram_stall_mem_o  (ram_stall_mem_o)
`ifdef RAM_ARB_PERF_CNT_EN
    ,
    .perf_if_grants_o  (perf_if_grants_o),
    .perf_mem_grants_o (perf_mem_grants_o),
    .perf_conflict_o   (perf_conflict_o)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    rst              = 1'b1;
    if_req_valid_i   = 1'b0;
    if_req_addr_i    = '0;
    if_flush_i       = 1'b0;
    mem_req_valid_i  = 1'b0;
    mem_req_we_i     = 1'b0;
    mem_req_addr_i   = '0;
    mem_req_wdata_i  = '0;
    mem_req_wmask_i  = '0;
    bus_req_ready_i  = 1'b0;
    bus_resp_valid_i = 1'b0;
    bus_resp_data_i  = '0;

    next_cycle();
    next_cycle();
    sample();
    check("rst_state", 64'(dut.state), 64'(ST_IDLE));
    check("rst_bus_valid", 64'(bus_req_valid_o), 64'd0);
    check("rst_bus_addr", 64'(bus_req_addr_o), 64'd0);
    check("rst_if_resp", 64'(if_resp_valid_o), 64'd0);
    check("rst_mem_resp", 64'(mem_resp_valid_o), 64'd0);
    next_cycle();
    rst = 1'b0;

    // IF read, minimum latency
    if_req_valid_i = 1'b1;
    if_req_addr_i  = 32'h8000_0000;
    bus_req_ready_i = 1'b1;
    sample();
    check("t1_c0_stall_if", 64'(ram_stall_if_o), 64'd1);
    check("t1_c0_bus_valid", 64'(bus_req_valid_o), 64'd0);
    next_cycle();
    sample();
    check("t1_c1_bus_valid", 64'(bus_req_valid_o), 64'd1);
    check("t1_c1_bus_addr", 64'(bus_req_addr_o), 64'h8000_0000);
    check("t1_c1_bus_we", 64'(bus_req_we_o), 64'd0);
    check("t1_c1_stall_if", 64'(ram_stall_if_o), 64'd1);
    next_cycle();
    bus_resp_valid_i = 1'b1;
    bus_resp_data_i  = 64'hDEAD;
    sample();
    check("t1_c2_if_resp", 64'(if_resp_valid_o), 64'd1);
    check("t1_c2_if_data", if_resp_data_o, 64'hDEAD);
    check("t1_c2_mem_resp", 64'(mem_resp_valid_o), 64'd0);
    check("t1_c2_stall_if", 64'(ram_stall_if_o), 64'd0);
    next_cycle();
    if_req_valid_i   = 1'b0;
    bus_resp_valid_i = 1'b0;
    bus_resp_data_i  = 64'h5555;
    sample();
    check("t1_c3_if_resp", 64'(if_resp_valid_o), 64'd0);
    check("t1_c3_if_hold", if_resp_data_o, 64'hDEAD);
    check("t1_c3_state", 64'(dut.state), 64'(ST_IDLE));
    next_cycle();

    // Simultaneous IF read and MEM write: MEM first
    if_req_valid_i  = 1'b1;
    if_req_addr_i   = 32'h200;
    mem_req_valid_i = 1'b1;
    mem_req_we_i    = 1'b1;
    mem_req_addr_i  = 32'h100;
    mem_req_wdata_i = 64'h1122_3344_5566_7788;
    mem_req_wmask_i = 8'h0F;
    sample();
    check("t2_c0_stall_mem", 64'(ram_stall_mem_o), 64'd1);
    check("t2_c0_stall_if", 64'(ram_stall_if_o), 64'd1);
    next_cycle();
    sample();
    check("t2_c1_bus_valid", 64'(bus_req_valid_o), 64'd1);
    check("t2_c1_bus_we", 64'(bus_req_we_o), 64'd1);
    check("t2_c1_bus_addr", 64'(bus_req_addr_o), 64'h100);
    check("t2_c1_bus_mask", 64'(bus_req_wmask_o), 64'h0F);
    check("t2_c1_bus_wdata", bus_req_wdata_o, 64'h1122_3344_5566_7788);
    next_cycle();
    bus_resp_valid_i = 1'b1;
    bus_resp_data_i  = 64'hCAFE;
    sample();
    check("t2_c2_mem_resp", 64'(mem_resp_valid_o), 64'd1);
    check("t2_c2_mem_data", mem_resp_data_o, 64'hCAFE);
    check("t2_c2_if_resp", 64'(if_resp_valid_o), 64'd0);
    next_cycle();
    mem_req_valid_i  = 1'b0;
    bus_resp_valid_i = 1'b0;
    sample();
    check("t2_c3_state", 64'(dut.state), 64'(ST_IDLE));
    check("t2_c3_bus_valid", 64'(bus_req_valid_o), 64'd0);
    next_cycle();
    sample();
    check("t2_c4_bus_addr", 64'(bus_req_addr_o), 64'h200);
    check("t2_c4_bus_we", 64'(bus_req_we_o), 64'd0);
    check("t2_c4_bus_mask", 64'(bus_req_wmask_o), 64'd0);
    check("t2_c4_bus_wdata", bus_req_wdata_o, 64'd0);
    next_cycle();
    bus_resp_valid_i = 1'b1;
    bus_resp_data_i  = 64'hBEEF;
    sample();
    check("t2_c5_if_resp", 64'(if_resp_valid_o), 64'd1);
    check("t2_c5_if_data", if_resp_data_o, 64'hBEEF);
    check("t2_c5_mem_resp", 64'(mem_resp_valid_o), 64'd0);
    check("t2_c5_mem_hold", mem_resp_data_o, 64'hCAFE);
    next_cycle();
    if_req_valid_i   = 1'b0;
    bus_resp_valid_i = 1'b0;
    next_cycle();

    // Starvation guard: four MEM grants, then IF is forced through
    if_req_valid_i  = 1'b1;
    if_req_addr_i   = 32'h300;
    mem_req_valid_i = 1'b1;
    mem_req_we_i    = 1'b0;
    mem_req_addr_i  = 32'h400;
    mem_req_wdata_i = '0;
    mem_req_wmask_i = '0;
    for (int k = 0; k < 5; k++) begin
      bus_resp_valid_i = 1'b0;
      sample();
      check($sformatf("t3_k%0d_idle_state", k), 64'(dut.state), 64'(ST_IDLE));
      next_cycle();
      sample();
      check($sformatf("t3_k%0d_addr", k), 64'(bus_req_addr_o), (k < 4) ? 64'h400 : 64'h300);
      check($sformatf("t3_k%0d_starve", k), 64'(dut.starve_cnt), (k < 4) ? 64'(k + 1) : 64'd0);
      next_cycle();
      bus_resp_valid_i = 1'b1;
      bus_resp_data_i  = 64'(k + 16);
      sample();
      check($sformatf("t3_k%0d_mem_resp", k), 64'(mem_resp_valid_o), (k < 4) ? 64'd1 : 64'd0);
      check($sformatf("t3_k%0d_if_resp", k), 64'(if_resp_valid_o), (k < 4) ? 64'd0 : 64'd1);
      next_cycle();
    end
    if_req_valid_i   = 1'b0;
    mem_req_valid_i  = 1'b0;
    bus_resp_valid_i = 1'b0;
    next_cycle();

    // Backpressure: ready low for five cycles
    bus_req_ready_i = 1'b0;
    mem_req_valid_i = 1'b1;
    mem_req_we_i    = 1'b1;
    mem_req_addr_i  = 32'h500;
    mem_req_wdata_i = 64'hA5A5_A5A5;
    mem_req_wmask_i = 8'hFF;
    next_cycle();
    for (int k = 0; k < 5; k++) begin
      sample();
      check($sformatf("t4_w%0d_valid", k), 64'(bus_req_valid_o), 64'd1);
      check($sformatf("t4_w%0d_addr", k), 64'(bus_req_addr_o), 64'h500);
      check($sformatf("t4_w%0d_wdata", k), bus_req_wdata_o, 64'hA5A5_A5A5);
      check($sformatf("t4_w%0d_state", k), 64'(dut.state), 64'(ST_REQ));
      next_cycle();
    end
    bus_req_ready_i = 1'b1;
    sample();
    check("t4_hs_valid", 64'(bus_req_valid_o), 64'd1);
    next_cycle();
    bus_resp_valid_i = 1'b1;
    bus_resp_data_i  = '0;
    sample();
    check("t4_mem_resp", 64'(mem_resp_valid_o), 64'd1);
    next_cycle();
    mem_req_valid_i  = 1'b0;
    bus_resp_valid_i = 1'b0;
    next_cycle();

    // IF flush during RESP, MEM pending behind it
    if_req_valid_i = 1'b1;
    if_req_addr_i  = 32'h600;
    next_cycle();
    mem_req_valid_i = 1'b1;
    mem_req_we_i    = 1'b0;
    mem_req_addr_i  = 32'h700;
    mem_req_wmask_i = '0;
    sample();
    check("t5_c1_addr", 64'(bus_req_addr_o), 64'h600);
    next_cycle();
    if_flush_i       = 1'b1;
    bus_resp_valid_i = 1'b1;
    bus_resp_data_i  = 64'h1234;
    sample();
    check("t5_c2_if_resp", 64'(if_resp_valid_o), 64'd0);
    check("t5_c2_mem_resp", 64'(mem_resp_valid_o), 64'd0);
    check("t5_c2_if_hold", if_resp_data_o, 64'(20));
    next_cycle();
    if_req_valid_i   = 1'b0;
    if_flush_i       = 1'b0;
    bus_resp_valid_i = 1'b0;
    sample();
    check("t5_c3_state", 64'(dut.state), 64'(ST_IDLE));
    next_cycle();
    sample();
    check("t5_c4_addr", 64'(bus_req_addr_o), 64'h700);
    check("t5_c4_we", 64'(bus_req_we_o), 64'd0);
    next_cycle();
    if_flush_i       = 1'b1;
    bus_resp_valid_i = 1'b1;
    bus_resp_data_i  = 64'h77;
    sample();
    check("t5_c5_mem_resp", 64'(mem_resp_valid_o), 64'd1);
    check("t5_c5_mem_data", mem_resp_data_o, 64'h77);
    next_cycle();
    mem_req_valid_i  = 1'b0;
    if_flush_i       = 1'b0;
    bus_resp_valid_i = 1'b0;
    next_cycle();

    // Reset during RESP, then a late bus response
    if_req_valid_i = 1'b1;
    if_req_addr_i  = 32'h800;
    next_cycle();
    next_cycle();
    sample();
    check("t6_in_resp", 64'(dut.state), 64'(ST_RESP));
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst              = 1'b0;
    if_req_valid_i   = 1'b0;
    bus_resp_valid_i = 1'b1;
    bus_resp_data_i  = 64'h99;
    sample();
    check("t6_state", 64'(dut.state), 64'(ST_IDLE));
    check("t6_if_resp", 64'(if_resp_valid_o), 64'd0);
    check("t6_mem_resp", 64'(mem_resp_valid_o), 64'd0);
    check("t6_bus_valid", 64'(bus_req_valid_o), 64'd0);
    check("t6_bus_addr", 64'(bus_req_addr_o), 64'd0);
    next_cycle();
    bus_resp_valid_i = 1'b0;
    sample();
    check("t6_still_idle", 64'(dut.state), 64'(ST_IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
